// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754-style multiplier (flush-to-zero, RNE) on valid/ready streams.
// Define FP_MUL_FLAGS_EN to add the registered {invalid, overflow, underflow, inexact} flags port.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned TAG_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] input_a,
  input  logic [EXP_W+MAN_W:0] input_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]           flags
`endif
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned XW = EXP_W + 2;
  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam logic signed [XW-1:0] Bias   = XW'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] ExpMax = XW'((2 ** EXP_W) - 1);
  localparam logic signed [XW-1:0] ExpOne = XW'(1);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1 unpack and classify; subnormals count as zero.
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inf_zero;

  assign ea       = input_a[W-2 -: EXP_W];
  assign eb       = input_b[W-2 -: EXP_W];
  assign ma       = input_a[MAN_W-1:0];
  assign mb       = input_b[MAN_W-1:0];
  assign a_zero   = (ea == '0);
  assign b_zero   = (eb == '0);
  assign a_inf    = (&ea) && (ma == '0);
  assign b_inf    = (&eb) && (mb == '0);
  assign a_nan    = (&ea) && (ma != '0);
  assign b_nan    = (&eb) && (mb != '0);
  assign inf_zero = (a_inf && b_zero) || (b_inf && a_zero);

  logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic signed [XW-1:0] s1_exp;
  logic [SW-1:0]        s1_siga, s1_sigb;
  logic [TAG_W-1:0]     s1_tag;

  logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
  logic signed [XW-1:0] s2_exp;
  logic [PW-1:0]        s2_prod;
  logic [TAG_W-1:0]     s2_tag;

`ifdef FP_MUL_FLAGS_EN
  logic       s1_inv, s2_inv;
  logic [3:0] flags_d;
`endif

  // Stage 3 normalise, round to nearest even, pack.
  logic                 hi, guard, sticky, rnd_up;
  logic [MAN_W-1:0]     man_t;
  logic [SW-1:0]        man_r;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]         res_d;

  always_comb begin
    hi     = s2_prod[PW-1];
    man_t  = hi ? s2_prod[PW-2 -: MAN_W] : s2_prod[PW-3 -: MAN_W];
    guard  = hi ? s2_prod[MAN_W] : s2_prod[MAN_W-1];
    sticky = hi ? |s2_prod[MAN_W-1:0] : |s2_prod[MAN_W-2:0];
    rnd_up = guard && (sticky || man_t[0]);
    man_r  = {1'b0, man_t} + SW'(rnd_up);
    // A rounding carry leaves the stored mantissa at zero and bumps the exponent.
    exp_r  = s2_exp + $signed({{(XW-1){1'b0}}, hi}) + $signed({{(XW-1){1'b0}}, man_r[MAN_W]});

    res_d = {s2_sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
    if (s2_nan) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (s2_inf) begin
      res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_zero || exp_r < ExpOne) begin
      res_d = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_r >= ExpMax) begin
      res_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

`ifdef FP_MUL_FLAGS_EN
    flags_d = '0;
    if (s2_nan) begin
      flags_d = {s2_inv, 3'b000};
    end else if (s2_inf || s2_zero) begin
      flags_d = '0;
    end else if (exp_r < ExpOne) begin
      flags_d = 4'b0011;
    end else if (exp_r >= ExpMax) begin
      flags_d = 4'b0101;
    end else begin
      flags_d = {3'b000, guard || sticky};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_exp    <= '0;
      s1_siga   <= '0;
      s1_sigb   <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_exp    <= '0;
      s2_prod   <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
`ifdef FP_MUL_FLAGS_EN
      s1_inv    <= 1'b0;
      s2_inv    <= 1'b0;
      flags     <= '0;
`endif
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_sign   <= input_a[W-1] ^ input_b[W-1];
      s1_nan    <= a_nan || b_nan || inf_zero;
      s1_inf    <= a_inf || b_inf;
      s1_zero   <= a_zero || b_zero;
      s1_exp    <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - Bias;
      s1_siga   <= {1'b1, ma};
      s1_sigb   <= {1'b1, mb};
      s1_tag    <= in_tag;
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_exp    <= s1_exp;
      s2_prod   <= PW'(s1_siga) * PW'(s1_sigb);
      s2_tag    <= s1_tag;
      out_valid <= s2_valid;
      result    <= res_d;
      out_tag   <= s2_tag;
`ifdef FP_MUL_FLAGS_EN
      // Signalling NaN has the mantissa MSB clear.
      s1_inv    <= inf_zero || (a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]);
      s2_inv    <= s1_inv;
      flags     <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: an fp16 instance for directed/stall/reset cases and an
// fp32 instance checked against an integer reference model.
`timescale 1ns/1ps
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_result;
  logic [7:0]  h_tag, h_out_tag;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_a, s_b, s_result;
  logic [7:0]  s_tag, s_out_tag;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]  h_flags, s_flags;
`endif

  fp_mul_pipe u_h (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .input_a   (h_a),
    .input_b   (h_b),
    .in_tag    (h_tag),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .result    (h_result),
    .out_tag   (h_out_tag)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags     (h_flags)
`endif
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(8)) u_s (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .input_a   (s_a),
    .input_b   (s_b),
    .in_tag    (s_tag),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .result    (s_result),
    .out_tag   (s_out_tag)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags     (s_flags)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [7:0]  tag;
    logic [3:0]  flg;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q_h[$];
  exp_t q_s[$];
  exp_t eh, es;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_out_h = 0;
  int   base_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // fp16 monitor: in_ready rule, head-of-queue compare (also while stalled), latency.
  always @(negedge clk) begin
    if (!reset) begin
      check(h_in_ready == (!h_out_valid || h_out_ready), "h_in_ready", 32'(h_in_ready),
            32'(!h_out_valid || h_out_ready));
      if (h_out_valid) begin
        if (q_h.size() == 0) begin
          check(1'b0, "h_unexpected_output", 32'(h_result), 32'h0);
        end else begin
          eh = q_h[0];
          check(h_result == eh.res[15:0], h_out_ready ? "h_result" : "h_stalled_result",
                32'(h_result), eh.res);
          check(h_out_tag == eh.tag, "h_tag", 32'(h_out_tag), 32'(eh.tag));
`ifdef FP_MUL_FLAGS_EN
          check(h_flags == eh.flg, "h_flags", 32'(h_flags), 32'(eh.flg));
`endif
          if (h_out_ready) begin
            if (eh.lat) check(cyc - eh.cyc == 3, "h_latency", 32'(cyc - eh.cyc), 32'd3);
            void'(q_h.pop_front());
            n_out_h++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && s_out_valid) begin
      if (q_s.size() == 0) begin
        check(1'b0, "s_unexpected_output", s_result, 32'h0);
      end else begin
        es = q_s[0];
        check(s_result == es.res, "s_result", s_result, es.res);
        check(s_out_tag == es.tag, "s_tag", 32'(s_out_tag), 32'(es.tag));
`ifdef FP_MUL_FLAGS_EN
        check(s_flags == es.flg, "s_flags", 32'(s_flags), 32'(es.flg));
`endif
        check(cyc - es.cyc == 3, "s_latency", 32'(cyc - es.cyc), 32'd3);
        void'(q_s.pop_front());
      end
    end
  end

  task automatic issue_h(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tag,
                         input logic [15:0] r, input logic [3:0] f, input bit lat);
    bit done = 1'b0;
    h_in_valid = 1'b1;
    h_a = a;
    h_b = b;
    h_tag = tag;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (h_in_ready) begin
        q_h.push_back('{res: 32'(r), tag: tag, flg: f, cyc: cyc, lat: lat});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    h_in_valid = 1'b0;
    if (!done) check(1'b0, "h_issue_timeout", 32'h0, 32'h1);
  endtask

  task automatic issue_s(input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag,
                         input logic [31:0] r, input logic [3:0] f);
    bit done = 1'b0;
    s_in_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_tag = tag;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (s_in_ready) begin
        q_s.push_back('{res: r, tag: tag, flg: f, cyc: cyc, lat: 1'b1});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    if (!done) check(1'b0, "s_issue_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain(input bit fp32);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((fp32 ? q_s.size() : q_h.size()) == 0) break;
    end
    check((fp32 ? q_s.size() : q_h.size()) == 0, fp32 ? "s_drain" : "h_drain",
          32'(fp32 ? q_s.size() : q_h.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Reference fp32 multiply: flush-to-zero, RNE by remainder-vs-half comparison.
  function automatic void ref_mul32(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f);
    int          ea = int'(a[30:23]);
    int          eb = int'(b[30:23]);
    int          e, sh;
    logic        sgn = a[31] ^ b[31];
    bit          za = (ea == 0), zb = (eb == 0);
    bit          ia = (ea == 255) && (a[22:0] == 0), ib = (eb == 255) && (b[22:0] == 0);
    bit          na = (ea == 255) && (a[22:0] != 0), nb = (eb == 255) && (b[22:0] != 0);
    bit          iz = (ia && zb) || (ib && za);
    logic [63:0] p, q, rem, half;
    f = 4'b0000;
    if (na || nb || iz) begin
      r = 32'h7FC0_0000;
      f[3] = iz || (na && !a[22]) || (nb && !b[22]);
    end else if (ia || ib) begin
      r = {sgn, 8'hFF, 23'h0};
    end else if (za || zb) begin
      r = {sgn, 31'h0};
    end else begin
      p = {40'h0, 1'b1, a[22:0]} * {40'h0, 1'b1, b[22:0]};
      sh = p[47] ? 24 : 23;
      e = ea + eb - 127 + (p[47] ? 1 : 0);
      q = p >> sh;
      rem = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
      f[0] = (rem != 0);
      if (e < 1) begin
        r = {sgn, 31'h0};
        f = 4'b0011;
      end else if (e >= 255) begin
        r = {sgn, 8'hFF, 23'h0};
        f = 4'b0101;
      end else begin
        r = {sgn, 8'(e), q[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rnd32();
    int          sel = int'($urandom_range(0, 9));
    logic [7:0]  e;
    logic [22:0] m = 23'($urandom);
    if (sel == 0) e = 8'hFF;
    else if (sel == 1) e = 8'h00;
    else if (sel < 4) e = 8'($urandom_range(0, 255));
    else e = 8'($urandom_range(100, 154));
    if (sel < 2 && $urandom_range(0, 1) == 0) m = '0;
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rr;
    logic [3:0]  rf;
    reset = 1'b1;
    h_in_valid = 1'b0; h_a = '0; h_b = '0; h_tag = '0; h_out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_tag = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check(h_out_valid == 1'b0, "rst_out_valid", 32'(h_out_valid), 32'h0);
    check(h_result == 16'h0, "rst_result", 32'(h_result), 32'h0);
    check(h_out_tag == 8'h0, "rst_out_tag", 32'(h_out_tag), 32'h0);
    check(h_in_ready == 1'b1, "rst_in_ready", 32'(h_in_ready), 32'h1);
    check(s_out_valid == 1'b0, "rst_s_out_valid", 32'(s_out_valid), 32'h0);
    @(posedge clk);
    #1;

    // Directed fp16 vectors; flags are {invalid, overflow, underflow, inexact}.
    issue_h(16'h3C00, 16'h4000, 8'h11, 16'h4000, 4'b0000, 1'b1);
    issue_h(16'h3E00, 16'h3E00, 8'h12, 16'h4080, 4'b0000, 1'b1);
    issue_h(16'h3E00, 16'h3C01, 8'h13, 16'h3E02, 4'b0001, 1'b1);
    issue_h(16'h3C01, 16'h3C01, 8'h14, 16'h3C02, 4'b0001, 1'b1);
    issue_h(16'h7BFF, 16'h4000, 8'h15, 16'h7C00, 4'b0101, 1'b1);
    issue_h(16'h7C00, 16'h0000, 8'h16, 16'h7E00, 4'b1000, 1'b1);
    issue_h(16'h0400, 16'h3800, 8'h17, 16'h0000, 4'b0011, 1'b1);
    issue_h(16'hFC00, 16'h4000, 8'h18, 16'hFC00, 4'b0000, 1'b1);
    issue_h(16'h4200, 16'h4200, 8'h19, 16'h4880, 4'b0000, 1'b1);
    issue_h(16'hC000, 16'h3C00, 8'h1A, 16'hC000, 4'b0000, 1'b1);
    issue_h(16'h7E00, 16'h3C00, 8'h1B, 16'h7E00, 4'b0000, 1'b1);
    issue_h(16'h7D00, 16'h3C00, 8'h1C, 16'h7E00, 4'b1000, 1'b1);
    issue_h(16'h0001, 16'h3C00, 8'h1D, 16'h0000, 4'b0000, 1'b1);
    issue_h(16'h8000, 16'h7C00, 8'h1E, 16'h7E00, 4'b1000, 1'b1);
    drain(1'b0);

    // Back-pressure: six ops, out_ready low for cycles 4-8 of the burst.
    base_out = n_out_h;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          issue_h(16'h4000, 16'h3C00 + 16'(i), 8'(i), 16'h4000 + 16'(i), 4'b0000, 1'b0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 h_out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 h_out_ready = 1'b1;
      end
    join
    drain(1'b0);
    check(n_out_h - base_out == 6, "bp_count", 32'(n_out_h - base_out), 32'd6);

    // Reset with three ops held in flight by a stalled output.
    h_out_ready = 1'b0;
    base_out = n_out_h;
    issue_h(16'h3C00, 16'h3C00, 8'hA0, 16'h3C00, 4'b0000, 1'b0);
    issue_h(16'h4000, 16'h4000, 8'hA1, 16'h4400, 4'b0000, 1'b0);
    issue_h(16'h4400, 16'h4000, 8'hA2, 16'h4800, 4'b0000, 1'b0);
    reset = 1'b1;
    q_h.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    h_out_ready = 1'b1;
    @(negedge clk);
    check(h_out_valid == 1'b0, "rst_mid_out_valid", 32'(h_out_valid), 32'h0);
    check(h_result == 16'h0, "rst_mid_result", 32'(h_result), 32'h0);
    repeat (8) @(posedge clk);
    #1;
    check(n_out_h == base_out, "rst_mid_no_output", 32'(n_out_h - base_out), 32'h0);

    // fp32 instance: one directed vector, then random vectors against the model.
    issue_s(32'h3FC0_0000, 32'h4000_0000, 8'h55, 32'h4040_0000, 4'b0000);
    for (int i = 0; i < 784; i++) begin
      ra = rnd32();
      rb = rnd32();
      ref_mul32(ra, rb, rr, rf);
      issue_s(ra, rb, 8'(i), rr, rf);
    end
    drain(1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
